// File: rtl/sr_flag_arbiter_pkg.sv
// sr_flag_arbiter_pkg: shared definitions for the SR flag arbiter and its sub-blocks.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package sr_flag_arbiter_pkg;

  // sr_flip command encodings {s,r}; 2'b11 is deliberately absent.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_RST  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_VERIFY = 2'd2
  } state_e;

  // Only two commands can ever be produced, so 2'b11 cannot be generated.
  function automatic logic [1:0] sr_cmd(input logic target);
    return target ? SR_SET : SR_RST;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first asserted req at or after ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the grant.
// Ports: req[N] requests, ptr start position (< N), grant one-hot, grant_id binary index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id
);

  localparam logic [PW:0] NW = (PW+1)'(N);

  logic [PW:0] idx;
  logic        found;

  // Walk the ring starting at ptr; the extra bit in idx absorbs ptr+i before wrapping,
  // so non-power-of-2 N never produces an index >= N.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= NW) begin
        idx = idx - NW;
      end
      if (!found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        grant[idx[PW-1:0]]   = 1'b1;
        grant_id             = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: shares one external SR flop between NREQ requesters, round-robin, one op at a time.
// Latency: req->done HOLD_CYC+2 cycles when the flop is driven, 2 cycles when the op is skipped (q already at target).
// Backpressure: requesters hold req until their done pulse; non-owners wait (ignored) until the block is IDLE.
// Ports: clk, rst (async active-high); req/op per requester; q from the flop;
//        sr_out {s,r} to the flop; gnt one-hot owner; done one-hot pulse; err pulse with done; busy.
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 1,
  parameter int SKIP_NOP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q,
  output logic [1:0]      sr_out,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            busy
);

  localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]    CNT_LOAD = 4'(HOLD_CYC - 1);
  localparam logic [PW-1:0] LAST_ID  = PW'(NREQ - 1);

  state_e          state_q,  state_d;
  logic [PW-1:0]   ptr_q,    ptr_d;
  logic [PW-1:0]   id_q,     id_d;
  logic            target_q, target_d;
  logic [3:0]      cnt_q,    cnt_d;
  logic [1:0]      sr_out_q, sr_out_d;
  logic [NREQ-1:0] gnt_q,    gnt_d;
  logic [NREQ-1:0] done_q,   done_d;
  logic            err_q,    err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_id;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req      (req),
    .ptr      (ptr_q),
    .grant    (arb_gnt),
    .grant_id (arb_id)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    sr_out_d = sr_out_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sr_out_d = SR_HOLD;
        gnt_d    = '0;
        if (|req) begin
          id_d     = arb_id;
          target_d = op[arb_id];
          gnt_d    = arb_gnt;
          if ((SKIP_NOP != 0) && (q == op[arb_id])) begin
            state_d = ST_VERIFY;
          end else begin
            state_d  = ST_DRIVE;
            sr_out_d = sr_cmd(op[arb_id]);
            cnt_d    = CNT_LOAD;
          end
        end
      end

      ST_DRIVE: begin
        // The command was loaded on DRIVE entry, so cnt==0 here means the HOLD_CYC-th edge is next.
        if (cnt_q == 4'd0) begin
          state_d  = ST_VERIFY;
          sr_out_d = SR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_VERIFY: begin
        // gnt_q already holds the owner's one-hot, reuse it for the done pulse.
        done_d   = gnt_q;
        err_d    = (q != target_q);
        gnt_d    = '0;
        sr_out_d = SR_HOLD;
        ptr_d    = (id_q == LAST_ID) ? '0 : id_q + PW'(1);
        state_d  = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        sr_out_d = SR_HOLD;
        gnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      target_q <= 1'b0;
      cnt_q    <= '0;
      sr_out_q <= SR_HOLD;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      sr_out_q <= sr_out_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sr_out = sr_out_q;
  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed bench for sr_flag_arbiter with a behavioural SR flop on each instance.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_sr_flag_arbiter;
  import sr_flag_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req, op;
  logic       q_flop  = 1'b0;
  logic       q_stuck = 1'b0;
  logic       q_dut;
  logic [1:0] sr_out;
  logic [3:0] gnt, done;
  logic       err, busy;

  logic [3:0] req3, op3;
  logic       q3_flop = 1'b0;
  logic [1:0] sr_out3;
  logic [3:0] gnt3, done3;
  logic       err3, busy3;

  int n_vec = 0;
  int n_bad = 0;

  assign q_dut = q_stuck ? 1'b0 : q_flop;

  sr_flag_arbiter #(.NREQ(4), .HOLD_CYC(1), .SKIP_NOP(1)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .q(q_dut),
    .sr_out(sr_out), .gnt(gnt), .done(done), .err(err), .busy(busy)
  );

  sr_flag_arbiter #(.NREQ(4), .HOLD_CYC(3), .SKIP_NOP(1)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .op(op3), .q(q3_flop),
    .sr_out(sr_out3), .gnt(gnt3), .done(done3), .err(err3), .busy(busy3)
  );

  // Behavioural sr_flip models; reset of the controller leaves them untouched.
  always @(posedge clk) begin
    if (sr_out == 2'b10) q_flop <= 1'b1;
    else if (sr_out == 2'b01) q_flop <= 1'b0;
  end
  always @(posedge clk) begin
    if (sr_out3 == 2'b10) q3_flop <= 1'b1;
    else if (sr_out3 == 2'b01) q3_flop <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every cycle: no 2'b11 command, at most one requester owns or completes.
  always @(negedge clk) begin
    if (!rst) begin
      chk("legal_every_cycle",
          32'(sr_out == 2'b11 || sr_out3 == 2'b11 ||
              !$onehot0(gnt | done) || !$onehot0(gnt3 | done3)), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output logic [3:0] d, output logic e, output int lat);
    d   = '0;
    e   = 1'b0;
    lat = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (done != 4'b0) begin
        d   = done;
        e   = err;
        lat = t;
        break;
      end
    end
    chk("done_seen", 32'(d != 4'b0), 32'd1);
  endtask

  logic [3:0] d;
  logic       e;
  int         lat;
  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         rr_lat [5] = '{2, 3, 3, 3, 3};
  int         cnt01;
  int         done_at;
  logic [3:0] done3_seen;

  initial begin
    rst  = 1'b1;
    req  = '0;
    op   = '0;
    req3 = '0;
    op3  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_sr_out", 32'(sr_out), 32'(SR_HOLD));
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_busy",   32'(busy),   32'd0);

    // Single SET from q=0: 10 for one cycle, done three cycles after req
    req = 4'b0001;
    op  = 4'b0001;
    tick();
    chk("set_sr_drive", 32'(sr_out), 32'h2);
    chk("set_gnt",      32'(gnt),    32'h1);
    chk("set_busy",     32'(busy),   32'd1);
    tick();
    chk("set_sr_verify", 32'(sr_out), 32'h0);
    chk("set_no_early_done", 32'(done), 32'd0);
    chk("set_q",        32'(q_flop), 32'd1);
    tick();
    chk("set_done",     32'(done),   32'h1);
    chk("set_err",      32'(err),    32'd0);
    req = '0;
    tick();
    chk("set_done_pulse", 32'(done), 32'd0);
    chk("set_idle",     32'(busy),   32'd0);

    // Skip path: q already 1, SET by requester 2 -> no sr pulse, done after 2 cycles
    req = 4'b0100;
    op  = 4'b0100;
    tick();
    chk("skip_sr",   32'(sr_out), 32'h0);
    chk("skip_gnt",  32'(gnt),    32'h4);
    chk("skip_done_early", 32'(done), 32'd0);
    tick();
    chk("skip_done", 32'(done),   32'h4);
    chk("skip_err",  32'(err),    32'd0);
    chk("skip_sr2",  32'(sr_out), 32'h0);
    chk("skip_q",    32'(q_flop), 32'd1);
    req = '0;
    tick();

    // Reset mid-DRIVE (RESET by requester 1 from q=1); ptr is 3 before this
    req = 4'b0010;
    op  = 4'b0000;
    tick();
    chk("mid_sr_drive", 32'(sr_out), 32'h1);
    chk("mid_gnt",      32'(gnt),    32'h2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_sr",   32'(sr_out), 32'h0);
    chk("mid_rst_gnt",  32'(gnt),    32'd0);
    chk("mid_rst_busy", 32'(busy),   32'd0);
    tick();
    chk("mid_rst_done", 32'(done),   32'd0);
    chk("mid_rst_err",  32'(err),    32'd0);
    chk("mid_rst_q",    32'(q_flop), 32'd1);
    rst = 1'b0;

    // Round robin with all requesting: ptr restarted at 0, order 0,1,2,3,0
    req = 4'b1111;
    op  = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      wait_done(d, e, lat);
      chk("rr_order", 32'(d),   32'(rr_exp[k]));
      chk("rr_err",   32'(e),   32'd0);
      chk("rr_lat",   32'(lat), 32'(rr_lat[k]));
    end
    req = '0;
    chk("rr_final_q", 32'(q_flop), 32'd1);
    tick();

    // q stuck at 0: SET by requester 1 (ptr now 1) completes with err
    q_stuck = 1'b1;
    req = 4'b0010;
    op  = 4'b0010;
    wait_done(d, e, lat);
    chk("stuck_done", 32'(d),   32'h2);
    chk("stuck_err",  32'(e),   32'd1);
    chk("stuck_lat",  32'(lat), 32'd3);
    req = '0;
    tick();
    chk("stuck_err_pulse", 32'(err), 32'd0);
    q_stuck = 1'b0;

    // HOLD_CYC=3 instance: first SET it to 1, then RESET and count 01 cycles
    req3 = 4'b0001;
    op3  = 4'b0001;
    done3_seen = '0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done3 != 4'b0) begin
        done3_seen = done3;
        break;
      end
    end
    chk("h3_set_done", 32'(done3_seen), 32'h1);
    req3 = '0;
    tick();
    chk("h3_set_q", 32'(q3_flop), 32'd1);

    req3 = 4'b0010;
    op3  = 4'b0000;
    cnt01 = 0;
    done_at = 0;
    done3_seen = '0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (sr_out3 == 2'b01) cnt01++;
      if (done3 != 4'b0 && done_at == 0) begin
        done_at    = t;
        done3_seen = done3;
        req3       = '0;
      end
    end
    chk("h3_rst_cycles", 32'(cnt01),      32'd3);
    chk("h3_rst_lat",    32'(done_at),    32'd5);
    chk("h3_rst_done",   32'(done3_seen), 32'h2);
    chk("h3_rst_q",      32'(q3_flop),    32'd0);
    chk("h3_idle",       32'(busy3),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
